bure_imem_responder: RTL

Memory-side responder for the core's instruction/data memory handshake: accepts read requests from a fetch or load stage, returns read data after a fixed pipeline latency through a small response buffer, and performs single-cycle writes. It sits at the far end of the memory interface, opposite the fetch stage, as the simulation/FPGA instruction memory. Flow control is credit-based, so no accepted request is ever dropped when the requester stalls `rdata_ready`.

---
 rtl/bure_mem_pkg.sv | 28 ++
 rtl/bure_rsp_fifo.sv | 51 +++++
 rtl/bure_imem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bure_mem_pkg.sv
// Shared definitions for the bure memory responder: address-to-index
// conversion, pipeline depth bound and the pipeline stage record.
package bure_mem_pkg;

    // Deepest read pipeline the responder supports.
    localparam int LAT_MAX = 4;

    // Width of the data field carried in a pipeline stage record.
    localparam int RSP_DATA_W = 32;

    // One read pipeline stage: a valid flag plus the word read from memory.
    typedef struct packed {
        logic                  valid;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

    // Byte address to word index. Bits [1:0] are dropped. Upper bits are
    // masked off, so addresses wrap modulo depth*4. Depth must be a power of two.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int unsigned depth);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = addr >> 2;
        mask    = 64'(depth) - 64'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/bure_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra bit so that full and
// empty can be told apart when the index bits are equal. The head is shown
// combinationally and stays put until popped.
module bure_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = storage[rd_ptr[AW-1:0]];

    // Advance the write pointer and store the pushed word; reset clears the
    // storage so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (push) begin
            storage[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr                  <= wr_ptr + 1'b1;
        end
    end

    // Advance the read pointer on every pop of a non-empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/bure_imem_responder.sv
// Memory-side responder for the core's instruction/data memory handshake.
// Reads travel through a LATENCY-deep valid/data pipeline into a response
// FIFO; a credit counter covering pipeline plus FIFO entries gates request
// acceptance so the FIFO can never overflow while the requester stalls.
// Writes take effect in one cycle with no backpressure.
module bure_imem_responder
    import bure_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1,
    parameter int RSP_DEPTH  = 4,
    parameter     INIT_FILE  = "imem.hex"
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_raddr_valid,
    output logic                  o_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  o_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_wen,
    input  logic                  i_wdata_valid,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    // Reject configurations the pipeline and credit scheme cannot honour.
    generate
        if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
            $error("bure_imem_responder: LATENCY must be 1..%0d", LAT_MAX);
        end
        if (RSP_DEPTH < LATENCY) begin : g_bad_rsp_depth
            $error("bure_imem_responder: RSP_DEPTH must be >= LATENCY");
        end
        if (DATA_WIDTH > RSP_DATA_W) begin : g_bad_width
            $error("bure_imem_responder: DATA_WIDTH exceeds pipeline record width");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      ridx;
    logic [IDX_W-1:0]      widx;
    logic                  accept;
    logic                  pop;
    logic                  wr_en;
    logic [CNT_W-1:0]      outstanding;
    rsp_t                  pipe [LATENCY];
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0] pipe_out_data;

    assign ridx          = IDX_W'(word_index(64'(i_raddr), DEPTH));
    assign widx          = IDX_W'(word_index(64'(i_waddr), DEPTH));
    assign o_raddr_ready = !i_rst && (outstanding < CNT_W'(RSP_DEPTH));
    assign accept        = i_raddr_valid && o_raddr_ready;
    assign pop           = o_rdata_valid && i_rdata_ready;
    assign wr_en         = i_wen && i_wdata_valid;
    assign o_rdata_valid = !fifo_empty;
    assign o_rdata       = fifo_head;
    assign pipe_out_data = pipe[LATENCY-1].data[DATA_WIDTH-1:0];

    // Single-cycle write; no reset so that contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[widx] <= i_wdata;
        end
    end

    // Read pipeline: stage 0 samples the array on accept (old data on a
    // same-cycle write to the same word), later stages shift the record on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0].valid <= accept;
            if (accept) begin
                pipe[0].data <= RSP_DATA_W'(mem[ridx]);
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Credit counter: every accepted request holds a credit until its
    // response is popped, covering both pipeline and FIFO occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    bure_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (pipe[LATENCY-1].valid),
        .push_data (pipe_out_data),
        .pop       (pop),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (fifo_head)
    );

    // The credit limit already prevents a push into a full FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_rst && pipe[LATENCY-1].valid && !pop) begin
            assert (!fifo_full) else $error("bure_imem_responder: push into full response FIFO");
        end
    end

endmodule
